// File: rtl/wb_pipe_pkg.sv
// Shared types and constants for the MEM->WB pipeline stage.
// Lane layout mirrors the default stage parameters.
package wb_pipe_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_RF_WIDTH   = 5;
    localparam int WB_LANES      = 1;

    typedef struct packed {
        logic                     regWrite;
        logic [WB_RF_WIDTH-1:0]   regAddr;
        logic [WB_DATA_WIDTH-1:0] regDin;
    } wb_lane_t;

    typedef wb_lane_t [WB_LANES-1:0] wb_beat_t;

    localparam logic [WB_RF_WIDTH-1:0] RF_ZERO_ADDR = '0;

endpackage

// File: rtl/wb_pipe_stage_if.sv
// MEM->WB beat bus: upstream beat plus downstream writeback beat.
// master drives the memory side and consumes writeback; slave is the stage.
interface wb_pipe_stage_if
    import wb_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RF_WIDTH   = 5,
    parameter int LANES      = 1
);
    logic                        inValid;
    logic                        inReady;
    logic [LANES-1:0]            regWriteM;
    logic [LANES*RF_WIDTH-1:0]   regAddr3M;
    logic [LANES*DATA_WIDTH-1:0] regDin3M;

    logic                        outValid;
    logic                        outReady;
    logic [LANES-1:0]            regWriteW;
    logic [LANES*RF_WIDTH-1:0]   regAddr3W;
    logic [LANES*DATA_WIDTH-1:0] regDin3W;

    modport master (
        output inValid, regWriteM, regAddr3M, regDin3M, outReady,
        input  inReady, outValid, regWriteW, regAddr3W, regDin3W
    );

    modport slave (
        input  inValid, regWriteM, regAddr3M, regDin3M, outReady,
        output inReady, outValid, regWriteW, regAddr3W, regDin3W
    );
endinterface

// File: rtl/wb_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; main reg drives the output.
// inReady is purely registered so there is no comb path from out_ready_i.
module wb_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept;
    logic         emit;

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_q;

    // flush blocks both handshakes for the cycle it is asserted
    assign accept = in_valid_i & ~skid_valid_q & ~flush_i;
    assign emit   = main_valid_q & out_ready_i & ~flush_i;

    // next-state: refill main from skid or input, overflow into skid
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (emit && skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
        end else if (accept && (!main_valid_q || emit)) begin
            main_d       = in_data_i;
            main_valid_d = 1'b1;
        end else if (accept) begin
            skid_d       = in_data_i;
            skid_valid_d = 1'b1;
        end else if (emit) begin
            main_valid_d = 1'b0;
        end
    end

    // state registers; data of an emptied main reg is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end
endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB stage: lane packing, x0 write gating, flush, skid buffering.
// Optional forward compare on the main reg under WB_PIPE_FWD_EN.
module wb_pipe_stage
    import wb_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RF_WIDTH   = 5,
    parameter int LANES      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
`ifdef WB_PIPE_FWD_EN
    input  logic [RF_WIDTH-1:0]   fwdAddr,
    output logic                  fwdHit,
    output logic [DATA_WIDTH-1:0] fwdData,
`endif
    wb_pipe_stage_if.slave        bus
);
    typedef struct packed {
        logic                  regWrite;
        logic [RF_WIDTH-1:0]   regAddr;
        logic [DATA_WIDTH-1:0] regDin;
    } lane_t;

    localparam int BEAT_W = LANES * $bits(lane_t);
    localparam logic [RF_WIDTH-1:0] ZERO_ADDR = RF_WIDTH'(RF_ZERO_ADDR);

    lane_t [LANES-1:0] in_beat;
    lane_t [LANES-1:0] out_beat;
    logic  [LANES-1:0] wr_w;
    logic              out_valid;
    logic              in_ready;

    // pack the flat per-lane buses into one beat
    always_comb begin
        in_beat = '0;
        for (int i = 0; i < LANES; i++) begin
            in_beat[i].regWrite = bus.regWriteM[i];
            in_beat[i].regAddr  = bus.regAddr3M[i*RF_WIDTH +: RF_WIDTH];
            in_beat[i].regDin   = bus.regDin3M[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    wb_skid_buf #(
        .W (BEAT_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (bus.inValid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_beat),
        .out_valid_o (out_valid),
        .out_ready_i (bus.outReady),
        .out_data_o  (out_beat)
    );

    assign bus.inReady  = in_ready;
    assign bus.outValid = out_valid;

    // unpack main reg; x0 writes are squashed here
    always_comb begin
        wr_w          = '0;
        bus.regAddr3W = '0;
        bus.regDin3W  = '0;
        for (int i = 0; i < LANES; i++) begin
            wr_w[i] = out_valid & out_beat[i].regWrite
                    & (out_beat[i].regAddr != ZERO_ADDR);
            bus.regAddr3W[i*RF_WIDTH +: RF_WIDTH]       = out_beat[i].regAddr;
            bus.regDin3W[i*DATA_WIDTH +: DATA_WIDTH]    = out_beat[i].regDin;
        end
    end

    assign bus.regWriteW = wr_w;

`ifdef WB_PIPE_FWD_EN
    // later lanes override earlier ones; x0 never has wr_w set
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        for (int i = 0; i < LANES; i++) begin
            if (wr_w[i] && (out_beat[i].regAddr == fwdAddr)) begin
                fwdHit  = 1'b1;
                fwdData = out_beat[i].regDin;
            end
        end
    end
`endif
endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench for wb_pipe_stage with LANES=2.
// Define WB_PIPE_FWD_EN to also exercise the forward compare.
module tb_wb_pipe_stage;
    import wb_pipe_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int LN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    int   tests = 0;
    int   fails = 0;

`ifdef WB_PIPE_FWD_EN
    logic [RW-1:0] fwdAddr = '0;
    logic          fwdHit;
    logic [DW-1:0] fwdData;
`endif

    wb_pipe_stage_if #(.DATA_WIDTH(DW), .RF_WIDTH(RW), .LANES(LN)) bus ();

    wb_pipe_stage #(
        .DATA_WIDTH (DW),
        .RF_WIDTH   (RW),
        .LANES      (LN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
`ifdef WB_PIPE_FWD_EN
        .fwdAddr (fwdAddr),
        .fwdHit  (fwdHit),
        .fwdData (fwdData),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input logic w1, input logic [4:0] a1,
                            input logic [31:0] d1, input logic w0,
                            input logic [4:0] a0, input logic [31:0] d0);
        bus.regWriteM = {w1, w0};
        bus.regAddr3M = {a1, a0};
        bus.regDin3M  = {d1, d0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.inValid  = 1'b0;
        bus.outReady = 1'b0;
        set_beat(0, 0, 0, 0, 0, 0);

        // reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_outValid", 64'(bus.outValid), 64'd0);
        chk("rst_inReady", 64'(bus.inReady), 64'd1);
        chk("rst_regWriteW", 64'(bus.regWriteW), 64'd0);
        chk("rst_regDin3W", bus.regDin3W, 64'd0);
        #9 rst_n = 1'b1;
        step();

        // 1: single beat, lane1 targets x0
        bus.outReady = 1'b1;
        bus.inValid  = 1'b1;
        set_beat(1, 5'd0, 32'd5, 1, 5'd3, 32'hA5A5_0001);
        step();
        bus.inValid = 1'b0;
        chk("t1_outValid", 64'(bus.outValid), 64'd1);
        chk("t1_regWriteW", 64'(bus.regWriteW), 64'b01);
        chk("t1_din_l0", 64'(bus.regDin3W[31:0]), 64'hA5A5_0001);
        chk("t1_addr_l0", 64'(bus.regAddr3W[4:0]), 64'd3);
        step();
        chk("t1_drained", 64'(bus.outValid), 64'd0);
        chk("t1_hold_din", 64'(bus.regDin3W[31:0]), 64'hA5A5_0001);
        chk("t1_wr_gated", 64'(bus.regWriteW), 64'd0);

        // lane0 off, lane1 live
        bus.inValid = 1'b1;
        set_beat(1, 5'd31, 32'h77, 0, 5'd4, 32'h66);
        step();
        bus.inValid = 1'b0;
        chk("x0_lane1_only", 64'(bus.regWriteW), 64'b10);
        step();

        // 2: streaming at full rate
        bus.inValid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_beat(0, 5'(k + 9), 32'h200 + k, 1, 5'(k + 1), 32'h100 + k);
            step();
            chk("t2_outValid", 64'(bus.outValid), 64'd1);
            chk("t2_din", 64'(bus.regDin3W[31:0]), 64'(32'h100 + k));
            chk("t2_inReady", 64'(bus.inReady), 64'd1);
            chk("t2_wr", 64'(bus.regWriteW), 64'b01);
        end
        bus.inValid = 1'b0;
        step();
        chk("t2_drained", 64'(bus.outValid), 64'd0);

        // 3: backpressure fills skid, release keeps order
        bus.outReady = 1'b0;
        bus.inValid  = 1'b1;
        set_beat(0, 0, 0, 1, 5'd1, 32'h301);
        step();
        chk("t3_a_valid", 64'(bus.outValid), 64'd1);
        chk("t3_a_ready", 64'(bus.inReady), 64'd1);
        set_beat(0, 0, 0, 1, 5'd2, 32'h302);
        step();
        chk("t3_b_ready", 64'(bus.inReady), 64'd0);
        chk("t3_b_din", 64'(bus.regDin3W[31:0]), 64'h301);
        set_beat(0, 0, 0, 1, 5'd3, 32'h303);
        step();
        chk("t3_full_ready", 64'(bus.inReady), 64'd0);
        chk("t3_full_din", 64'(bus.regDin3W[31:0]), 64'h301);
        bus.outReady = 1'b1;
        step();
        chk("t3_rel1_din", 64'(bus.regDin3W[31:0]), 64'h302);
        chk("t3_rel1_ready", 64'(bus.inReady), 64'd1);
        step();
        bus.inValid = 1'b0;
        chk("t3_rel2_din", 64'(bus.regDin3W[31:0]), 64'h303);
        chk("t3_rel2_valid", 64'(bus.outValid), 64'd1);
        step();
        chk("t3_drained", 64'(bus.outValid), 64'd0);

        // 4: flush a full stage with a beat presented
        bus.outReady = 1'b0;
        bus.inValid  = 1'b1;
        set_beat(0, 0, 0, 1, 5'd4, 32'h401);
        step();
        set_beat(0, 0, 0, 1, 5'd5, 32'h402);
        step();
        chk("t4_full", 64'(bus.inReady), 64'd0);
        set_beat(0, 0, 0, 1, 5'd6, 32'h403);
        flush = 1'b1;
        #1;
        chk("t4_flush_cycle_valid", 64'(bus.outValid), 64'd1);
        step();
        flush = 1'b0;
        bus.inValid = 1'b0;
        chk("t4_valid", 64'(bus.outValid), 64'd0);
        chk("t4_ready", 64'(bus.inReady), 64'd1);
        bus.outReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_no_emit", 64'(bus.outValid), 64'd0);
        end

        // 5: async reset mid-stream
        bus.outReady = 1'b0;
        bus.inValid  = 1'b1;
        set_beat(0, 0, 0, 1, 5'd5, 32'h501);
        step();
        chk("t5_pre_valid", 64'(bus.outValid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(bus.outValid), 64'd0);
        chk("t5_wr", 64'(bus.regWriteW), 64'd0);
        chk("t5_din", bus.regDin3W, 64'd0);
        chk("t5_ready", 64'(bus.inReady), 64'd1);
        bus.inValid = 1'b0;
        #1 rst_n = 1'b1;
        step();

`ifdef WB_PIPE_FWD_EN
        // 6: forward compare, highest lane wins
        bus.inValid = 1'b1;
        set_beat(1, 5'd7, 32'h22, 1, 5'd7, 32'h11);
        step();
        bus.inValid = 1'b0;
        fwdAddr = 5'd7;
        #1;
        chk("t6_hit", 64'(fwdHit), 64'd1);
        chk("t6_data", 64'(fwdData), 64'h22);
        fwdAddr = 5'd0;
        #1;
        chk("t6_x0_hit", 64'(fwdHit), 64'd0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
